gray_fifo_wptr: RTL and testbench



---
 rtl/fifo_pkg.sv | 27 ++
 rtl/gray_sync.sv | 28 ++
 rtl/inc_gray.sv | 38 +++
 rtl/gray_fifo_wptr.sv | 83 ++++++++
 tb/tb_gray_fifo_wptr.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared pointer helpers for the async FIFO pointer blocks.
// Functions work on a wide container; callers truncate to their pointer width.
package fifo_pkg;

  localparam int unsigned MaxPtrWidth = 32;

  typedef logic [MaxPtrWidth-1:0] wide_ptr_t;

  function automatic int unsigned ptr_width(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

  function automatic wide_ptr_t bin2gray(input wide_ptr_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // XOR-prefix from the MSB down; zero-extended upper bits leave low bits exact.
  function automatic wide_ptr_t gray2bin(input wide_ptr_t gray);
    wide_ptr_t bin;
    bin[MaxPtrWidth-1] = gray[MaxPtrWidth-1];
    for (int i = MaxPtrWidth - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing into clk_i.
// Shared by the write- and read-side pointer managers.
module gray_sync #(
  parameter int Width = 3,
  parameter int Depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] stage_q [Depth];

  // NOTE: every stage is cleared, not just the last one; a stale value left in
  // an early stage would surface as a bogus read pointer a few cycles later.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < Depth; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[Depth-1];

endmodule

// File: rtl/inc_gray.sv
// Combinational Gray-code incrementer, wrapping 100..0 back to 000..0.
// Speed 0 round-trips through binary; Speed 1/2 flips one bit directly.
module IncGray
  import fifo_pkg::*;
#(
  parameter int Width = 3,
  parameter int Speed = 1
) (
  input  logic [Width-1:0] gray_i,
  output logic [Width-1:0] gray_o
);

  if (Speed == 0) begin : g_roundtrip
    logic [Width-1:0] bin_inc;
    assign bin_inc = Width'(gray2bin(wide_ptr_t'(gray_i))) + Width'(1);
    assign gray_o  = Width'(bin2gray(wide_ptr_t'(bin_inc)));
  end else begin : g_direct
    logic found;
    // NOTE: defaults first so every path assigns every output; no latches.
    always_comb begin
      gray_o = gray_i;
      found  = 1'b0;
      if (!(^gray_i)) begin
        gray_o[0] = ~gray_i[0];
      end else begin
        // Odd parity: flip the bit just above the lowest set bit.
        for (int i = 0; i < Width - 1; i++) begin
          if (!found && gray_i[i]) begin
            gray_o[i+1] = ~gray_i[i+1];
            found       = 1'b1;
          end
        end
        if (!found) gray_o[Width-1] = ~gray_i[Width-1];
      end
    end
  end

endmodule

// File: rtl/gray_fifo_wptr.sv
// Write-side pointer, fill level and full flag for an asynchronous FIFO.
// Read pointer arrives Gray-coded from the read domain and is synchronised here.
module gray_fifo_wptr
  import fifo_pkg::*;
#(
  parameter int AddrWidth  = 4,
  parameter int SyncStages = 2,
  parameter int Speed      = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 push_i,
  input  logic [AddrWidth:0]   rptr_gray_async_i,
  output logic                 wen_o,
  output logic [AddrWidth-1:0] waddr_o,
  output logic                 full_o,
  output logic [AddrWidth:0]   fill_o,
  output logic [AddrWidth:0]   wptr_gray_o
);

  localparam int PtrWidth = ptr_width(AddrWidth);

  logic [PtrWidth-1:0] wptr_gray_q;
  logic [PtrWidth-1:0] wbin_q;
  logic [PtrWidth-1:0] wgray_inc;
  logic [PtrWidth-1:0] wnext;
  logic [PtrWidth-1:0] rsync;
  logic [PtrWidth-1:0] rbin;
  logic [PtrWidth-1:0] full_pattern;
  logic                full_q;
  logic                accept;

  IncGray #(
    .Width(PtrWidth),
    .Speed(Speed)
  ) u_inc_gray (
    .gray_i(wptr_gray_q),
    .gray_o(wgray_inc)
  );

  gray_sync #(
    .Width(PtrWidth),
    .Depth(SyncStages)
  ) u_rptr_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   (rptr_gray_async_i),
    .q_o   (rsync)
  );

  assign accept = push_i & ~full_q;
  assign wnext  = accept ? wgray_inc : wptr_gray_q;

  // Full when the write pointer is one lap ahead: top two Gray bits inverted.
  if (AddrWidth == 1) begin : g_full_narrow
    assign full_pattern = ~rsync;
  end else begin : g_full_wide
    assign full_pattern = {~rsync[PtrWidth-1:PtrWidth-2], rsync[PtrWidth-3:0]};
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_gray_q <= '0;
      wbin_q      <= '0;
      full_q      <= 1'b0;
    end else begin
      if (accept) begin
        wptr_gray_q <= wgray_inc;
        wbin_q      <= wbin_q + PtrWidth'(1);
      end
      full_q <= (wnext == full_pattern);
    end
  end

  assign rbin        = PtrWidth'(gray2bin(wide_ptr_t'(rsync)));
  assign fill_o      = wbin_q - rbin;
  assign wen_o       = accept;
  assign waddr_o     = wbin_q[AddrWidth-1:0];
  assign full_o      = full_q;
  assign wptr_gray_o = wptr_gray_q;

endmodule

// File: tb/tb_gray_fifo_wptr.sv
// Directed bench for gray_fifo_wptr with AddrWidth=2, SyncStages=2.
// Expected values are hand-computed from the 3-bit Gray sequence.
module tb_gray_fifo_wptr;

  logic       clk;
  logic       rst_n;
  logic       push;
  logic [2:0] rptr;
  logic       wen;
  logic [1:0] waddr;
  logic       full;
  logic [2:0] fill;
  logic [2:0] wptr;

  int checks = 0;
  int errors = 0;

  logic [2:0] gray_seq [8] = '{3'b000, 3'b001, 3'b011, 3'b010,
                               3'b110, 3'b111, 3'b101, 3'b100};

  gray_fifo_wptr #(
    .AddrWidth (2),
    .SyncStages(2),
    .Speed     (1)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .push_i           (push),
    .rptr_gray_async_i(rptr),
    .wen_o            (wen),
    .waddr_o          (waddr),
    .full_o           (full),
    .fill_o           (fill),
    .wptr_gray_o      (wptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs(input string tag, input logic [2:0] exp_wptr,
                            input logic exp_full, input logic [2:0] exp_fill);
    check({tag, "_wptr"}, 32'(wptr), 32'(exp_wptr));
    check({tag, "_full"}, 32'(full), 32'(exp_full));
    check({tag, "_fill"}, 32'(fill), 32'(exp_fill));
  endtask

  initial begin
    rst_n = 1'b0;
    push  = 1'b0;
    rptr  = 3'b000;

    // 1. reset, then idle
    cycle();
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check_regs("t1", 3'b000, 1'b0, 3'd0);
      check("t1_wen", 32'(wen), 32'd0);
      check("t1_waddr", 32'(waddr), 32'd0);
    end

    // 2. fill to full with rptr held at 000; extra pushes dropped
    push = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("t2_wen", 32'(wen), (i < 4) ? 32'd1 : 32'd0);
      check("t2_waddr", 32'(waddr), (i < 4) ? 32'(i) : 32'd0);
      cycle();
      check_regs("t2", gray_seq[(i < 4) ? i + 1 : 4], (i >= 3), 3'((i < 4) ? i + 1 : 4));
    end

    // 3. read pointer advances; full drops 3 edges later
    push = 1'b0;
    rptr = 3'b001;
    cycle();
    check_regs("t3_e1", 3'b110, 1'b1, 3'd4);
    cycle();
    check_regs("t3_e2", 3'b110, 1'b1, 3'd3);
    cycle();
    check_regs("t3_e3", 3'b110, 1'b0, 3'd3);
    push = 1'b1;
    #1;
    check("t3_wen", 32'(wen), 32'd1);
    check("t3_waddr", 32'(waddr), 32'd0);
    cycle();
    check_regs("t3_push", 3'b111, 1'b1, 3'd4);
    push = 1'b0;

    // 4. continuous push, rptr tracks wptr one cycle behind; wrap-around
    rst_n = 1'b0;
    rptr  = 3'b000;
    cycle();
    rst_n = 1'b1;
    check_regs("t4_rst", 3'b000, 1'b0, 3'd0);
    for (int n = 1; n <= 10; n++) begin
      push = 1'b1;
      #1;
      check("t4_wen", 32'(wen), 32'd1);
      check("t4_waddr", 32'(waddr), 32'((n - 1) % 4));
      cycle();
      check_regs("t4", gray_seq[n % 8], 1'b0, 3'((n < 2) ? n : 2));
      rptr = gray_seq[n % 8];
    end
    push = 1'b0;

    // 5. fill to full, then reset during a push
    cycle();
    cycle();
    check_regs("t5_idle", 3'b011, 1'b0, 3'd0);
    push = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    check_regs("t5_full", 3'b101, 1'b1, 3'd4);
    rst_n = 1'b0;
    rptr  = 3'b000;
    cycle();
    check_regs("t5_rst", 3'b000, 1'b0, 3'd0);
    check("t5_rst_waddr", 32'(waddr), 32'd0);
    rst_n = 1'b1;
    push  = 1'b0;
    #1;
    check("t5_wen", 32'(wen), 32'd0);
    cycle();
    check_regs("t5_after", 3'b000, 1'b0, 3'd0);

    // 6. read pointer changes on the push that fills the FIFO
    push = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    check_regs("t6_3push", 3'b010, 1'b0, 3'd3);
    rptr = 3'b001;
    #1;
    check("t6_wen", 32'(wen), 32'd1);
    check("t6_waddr", 32'(waddr), 32'd3);
    cycle();
    push = 1'b0;
    check_regs("t6_e1", 3'b110, 1'b1, 3'd4);
    cycle();
    check_regs("t6_e2", 3'b110, 1'b1, 3'd3);
    cycle();
    check_regs("t6_e3", 3'b110, 1'b0, 3'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
